instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction decoder/controller. Holds the PC and
//  requests words from instruction memory over a req/ack handshake. Latches each returned
//  word into the instruction register and presents opcode/control/funct fields to the
//  controller. Consumes the controller's jump decision (JR: funct==8) to redirect the PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; first fetch address
//  PC_STEP    4              byte increment per sequential fetch
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  imem_addr      out  32  fetch address (byte address, word aligned)
//  imem_req       out  1   fetch request; held high until imem_ack
//  imem_ack       in   1   memory returns imem_rdata this cycle
//  imem_rdata     in   32  instruction word
//  instr_valid    out  1   instruction register holds an instruction for decode
//  decode_ready   in   1   decoder consumes the instruction when instr_valid && decode_ready
//  opcode         out  6   instr[31:26]
//  control_data   out  10  instr[15:6]
//  funct          out  6   instr[5:0]
//  instr_pc       out  32  PC of the instruction currently in the instruction register
//  jump           in   1   controller jump decision for the presented instruction
//  jump_target    in   32  redirect address (rs value), sampled with jump
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=FETCH, imem_req=0, instr_valid=0,
//   instr=0 (opcode/control_data/funct=0), instr_pc=0, imem_addr=RESET_PC.
//  FSM: FETCH -> WAIT -> HOLD -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc; go to WAIT next cycle.
//   WAIT: imem_req stays 1, imem_addr stable. On imem_ack: instr<=imem_rdata, instr_pc<=pc,
//    instr_valid<=1, imem_req<=0, go to HOLD. imem_ack outside WAIT is ignored.
//   HOLD: outputs stable while decode_ready=0. On decode_ready: instr_valid<=0; next pc as
//    below; go to FETCH.
//  Next-PC rule (at HOLD consume): jump=1 -> jump_target with bits[1:0] forced to 0; else
//   instr_pc+PC_STEP (32-bit, wraps 32'hFFFF_FFFC -> 0). jump sampled only on consume cycle.
//  Minimum latency: request to instr_valid is 2 cycles with ack in first WAIT cycle; one
//   instruction per 3 cycles at best. Unbounded ack wait; no timeout.
//  Reset asserted mid-WAIT: request dropped immediately; a late imem_ack after release is
//   ignored unless in WAIT.
//  opcode/control_data/funct are combinational slices of the instruction register; they
//   change only on imem_ack capture.
// CONFIGURATION
//  Macro DELAY_SLOT_EN:
//   defined: MIPS branch delay slot. On consume with jump=1, target stored in pending
//    register; next fetch is instr_pc+PC_STEP (slot); on consuming the slot, pc<=pending
//    target. A jump consumed while a target is pending is ignored (pending target wins).
//   undefined: redirect immediate; the instruction fetched after a jump is at the target.
// TESTING
//  1 reset, ack 1 cycle after each req, decode_ready=1, rdata=addr -> imem_addr sequence
//    0,4,8,C; instr_pc matches; instr_valid pulses every 3 cycles.
//  2 ack delayed 5 cycles -> imem_req high and imem_addr constant for all 5 cycles; exactly
//    one capture.
//  3 decode_ready low 4 cycles in HOLD -> opcode/funct/instr_pc stable; no new imem_req.
//  4 at instr_pc=8, jump=1, jump_target=32'h0000_0103 -> next imem_addr 32'h100; with
//    DELAY_SLOT_EN: 32'hC then 32'h100.
//  5 RESET_PC=32'hFFFF_FFFC, sequential -> second fetch address 32'h0000_0000.
//  6 reset_n low during WAIT, ack arrives during reset -> imem_req=0 immediately; after
//    release first fetch at RESET_PC, instr_valid=0 until new ack.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of the instruction decoder/controller.
// It owns the program counter and requests one word at a time from
// instruction memory over a req/ack handshake. Each returned word is latched
// into the instruction register and offered to the controller until it is
// consumed. The controller's jump decision (JR) for the presented instruction
// redirects the PC.
//
// Sequence per instruction: FETCH -> WAIT (until imem_ack) -> HOLD (until
// decode_ready) -> FETCH. At best one instruction every three cycles.
//
// Parameters
//   RESET_PC      PC loaded on reset; address of the first fetch
//   PC_STEP       byte increment between sequential fetches
//
// Ports
//   clk           clock, rising edge
//   reset_n       asynchronous assert, synchronous release, active low
//   imem_addr     fetch byte address (word aligned)
//   imem_req      fetch request, held until imem_ack while waiting
//   imem_ack      memory returns imem_rdata this cycle
//   imem_rdata    instruction word from memory
//   instr_valid   instruction register holds an instruction for decode
//   decode_ready  decoder takes the instruction when instr_valid is high
//   opcode        instr[31:26]
//   control_data  instr[15:6]
//   funct         instr[5:0]
//   instr_pc      address of the instruction in the instruction register
//   jump          controller redirect decision, sampled on the consume cycle
//   jump_target   redirect address (rs value); low two bits are dropped
//
// Build option
//   DELAY_SLOT_EN  when defined, a jump takes effect after one delay-slot
//                  instruction (the word following the jump is still fetched
//                  and issued). When undefined, redirect is immediate.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic [5:0]  opcode,
  output logic [9:0]  control_data,
  output logic [5:0]  funct,
  output logic [31:0] instr_pc,
  input  logic        jump,
  input  logic [31:0] jump_target
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  logic        consume;
  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  // Jump targets come from a register value; force word alignment.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential successor; 32-bit add wraps naturally past the top of memory.
  function automatic logic [31:0] step_pc(input logic [31:0] addr);
    return addr + STEP;
  endfunction

  assign consume     = (state_q == S_HOLD) && decode_ready;
  assign seq_pc      = step_pc(instr_pc_q);
  assign redirect_pc = align_word(jump_target);

`ifdef DELAY_SLOT_EN
  // A taken jump parks its target here; the slot instruction (the word after
  // the jump) is fetched first and the target is applied when the slot is
  // consumed. While a target is parked, further jumps are ignored.
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    next_pc    = seq_pc;
    if (consume) begin
      if (pend_vld_q) begin
        next_pc    = pend_q;
        pend_vld_d = 1'b0;
      end else if (jump) begin
        pend_d     = redirect_pc;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`else
  assign next_pc = jump ? redirect_pc : seq_pc;
`endif

  // Next-state and register updates. imem_req is registered so that reset
  // drops it immediately and it never glitches; it is raised on the way into
  // FETCH (or while in FETCH after reset) and cleared by the capturing ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    req_d      = req_q;

    unique case (state_q)
      S_FETCH: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        req_d = 1'b1;
        // Only an ack seen here captures; acks in other states are ignored.
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (decode_ready) begin
          valid_d = 1'b0;
          pc_d    = next_pc;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end

      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  // The PC only moves on consume, so the address is stable across WAIT.
  assign imem_addr    = pc_q;
  assign imem_req     = req_q;
  assign instr_valid  = valid_q;
  assign instr_pc     = instr_pc_q;

  // Decode fields are plain slices of the instruction register.
  assign opcode       = instr_q[31:26];
  assign control_data = instr_q[15:6];
  assign funct        = instr_q[5:0];

endmodule
